nor_flash_ctrl: RTL

Parametrised parallel-NOR flash controller: power-up reset sequencing, single-word reads and unlock-sequenced single-word programs with ready/busy polling and timeout. It sits between the core's memory request port and the external flash pins and replaces hand-timed flash bring-up. Bus width, address width and all bus timings are parameters in clock cycles. The flash data bus is split into in/out/enable signals; the tristate lives at top level.

---
 rtl/nor_flash_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nor_flash_ctrl.sv
// Parallel-NOR flash controller: power-up reset sequencing, single-word reads and
// unlock-sequenced single-word programs with ready/busy polling and timeout.
module nor_flash_ctrl #(
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned RST_CYCLES   = 15000,
    parameter int unsigned RST_RECOVER  = 2,
    parameter int unsigned T_ACC        = 4,
    parameter int unsigned T_WP         = 3,
    parameter int unsigned T_WPH        = 2,
    parameter int unsigned PROG_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              init_done,
    input  logic              RDY_BSY,
    output logic              nMEMRST,
    output logic              nBYTE,
    output logic              nCE,
    output logic              nWE,
    output logic              nOE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DQ_OUT,
    output logic              DQ_OE,
    input  logic [DATA_W-1:0] DQ_IN
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // POLL cycles during which RDY_BSY is ignored while the flash raises busy
    localparam int unsigned BLANK   = 4;
    localparam int unsigned CNT_MAX = max2(max2(max2(RST_CYCLES, RST_RECOVER), max2(T_ACC, PROG_TIMEOUT)),
                                           max2(max2(T_WP, T_WPH), BLANK));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RST_RECOVER - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] WP_LAST  = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] WPH_LAST = CNT_W'(T_WPH - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(PROG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);

    localparam logic [ADDR_W-1:0] UA1 = (DATA_W == 16) ? ADDR_W'(12'h555) : ADDR_W'(12'hAAA);
    localparam logic [ADDR_W-1:0] UA2 = (DATA_W == 16) ? ADDR_W'(12'h2AA) : ADDR_W'(12'h555);

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_RST_WAIT,
        S_IDLE,
        S_RD,
        S_WR_LO,
        S_WR_HI,
        S_POLL,
        S_DONE
    } state_t;

    // Address/data of bus write cycle k of the program command sequence
    function automatic logic [ADDR_W-1:0] bus_addr(input logic [1:0] k, input logic [ADDR_W-1:0] a);
        case (k)
            2'd0, 2'd2: return UA1;
            2'd1:       return UA2;
            default:    return a;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] bus_data(input logic [1:0] k, input logic [DATA_W-1:0] d);
        case (k)
            2'd0:    return DATA_W'(8'hAA);
            2'd1:    return DATA_W'(8'h55);
            2'd2:    return DATA_W'(8'hA0);
            default: return d;
        endcase
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_k;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rb_s1;
    logic              r_rb_s2;
    logic              r_nmemrst;
    logic              r_nce;
    logic              r_nwe;
    logic              r_noe;
    logic [ADDR_W-1:0] r_addr_o;
    logic [DATA_W-1:0] r_dq_out;
    logic              r_dq_oe;
    logic              r_ready;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_init_done;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_RST_HOLD;
            r_cnt       <= '0;
            r_k         <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rb_s1     <= 1'b0;
            r_rb_s2     <= 1'b0;
            r_nmemrst   <= 1'b0;
            r_nce       <= 1'b1;
            r_nwe       <= 1'b1;
            r_noe       <= 1'b1;
            r_addr_o    <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_rb_s1 <= RDY_BSY;
            r_rb_s2 <= r_rb_s1;
            r_done  <= 1'b0;
            case (r_state)
                S_RST_HOLD: begin
                    if (r_cnt == RST_LAST) begin
                        r_cnt     <= '0;
                        r_nmemrst <= 1'b1;
                        r_state   <= S_RST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RST_WAIT: begin
                    if (r_cnt == REC_LAST) begin
                        r_cnt       <= '0;
                        r_init_done <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        r_ready <= 1'b0;
                        r_err   <= 1'b0;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= '0;
                        r_k     <= 2'd0;
                        r_nce   <= 1'b0;
                        if (we) begin
                            r_nwe    <= 1'b0;
                            r_dq_oe  <= 1'b1;
                            r_addr_o <= bus_addr(2'd0, addr);
                            r_dq_out <= bus_data(2'd0, wdata);
                            r_state  <= S_WR_LO;
                        end else begin
                            r_noe    <= 1'b0;
                            r_addr_o <= addr;
                            r_state  <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == ACC_LAST) begin
                        r_rdata <= DQ_IN;
                        r_nce   <= 1'b1;
                        r_noe   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR_LO: begin
                    if (r_cnt == WP_LAST) begin
                        r_cnt   <= '0;
                        r_nce   <= 1'b1;
                        r_nwe   <= 1'b1;
                        r_state <= S_WR_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR_HI: begin
                    if (r_cnt == WPH_LAST) begin
                        r_cnt <= '0;
                        if (r_k == 2'd3) begin
                            r_dq_oe <= 1'b0;
                            r_state <= S_POLL;
                        end else begin
                            r_k      <= r_k + 2'd1;
                            r_nce    <= 1'b0;
                            r_nwe    <= 1'b0;
                            r_addr_o <= bus_addr(r_k + 2'd1, r_addr);
                            r_dq_out <= bus_data(r_k + 2'd1, r_wdata);
                            r_state  <= S_WR_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_POLL: begin
                    if (r_cnt >= BLANK_C && r_rb_s2) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_RST_HOLD;
            endcase
        end
    end

    assign nBYTE     = (DATA_W == 16) ? 1'b1 : 1'b0;
    assign nMEMRST   = r_nmemrst;
    assign nCE       = r_nce;
    assign nWE       = r_nwe;
    assign nOE       = r_noe;
    assign ADDR      = r_addr_o;
    assign DQ_OUT    = r_dq_out;
    assign DQ_OE     = r_dq_oe;
    assign ready     = r_ready;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign init_done = r_init_done;

endmodule
